// File: rtl/ppu_pixel_fifo.sv
// ppu_pixel_fifo: pixel FIFO for the PPU draw pipeline.
// The tile fetcher pushes a whole row of ROW pixels per cycle, the LCD shifter
// pops one pixel per cycle (first-word-fall-through), and the sprite fetcher
// overlays a sprite row onto the ROW entries at the head.
// Ports:
//   clk, rstN       clock, async active-low reset
//   clear           synchronous flush, highest priority
//   push_valid/push_data/push_ready     row push (pixel 0 in the low bits)
//   merge_valid/merge_data/merge_ready  sprite overlay onto head..head+ROW-1
//   pop_en/pop_data/pop_valid           head pixel consume / view (pop_data 0 when empty)
//   count           current occupancy
//   underflow_err   sticky, set by a pop request while empty
// Pixel layout: [1:0] colour, [PX_W-2:2] palette/attr, [PX_W-1] src (1 = sprite).
module ppu_pixel_fifo #(
  parameter int unsigned PX_W  = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned ROW   = 8,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  clear,
  input  logic                  push_valid,
  input  logic [ROW*PX_W-1:0]   push_data,
  output logic                  push_ready,
  input  logic                  merge_valid,
  input  logic [ROW*PX_W-1:0]   merge_data,
  output logic                  merge_ready,
  input  logic                  pop_en,
  output logic [PX_W-1:0]       pop_data,
  output logic                  pop_valid,
  output logic [CW-1:0]         count,
  output logic                  underflow_err
);

  localparam int unsigned AW = CW - 1;

  // Parameter sanity check at elaboration.
  if (DEPTH < ROW || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("ppu_pixel_fifo: DEPTH must be a power of 2 and >= ROW");
  end

  logic [PX_W-1:0] mem [DEPTH];
  logic [CW-1:0]   wr_ptr;
  logic [CW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic            push_acc;
  logic            pop_acc;
  logic            merge_acc;
  logic [ROW-1:0]  merge_wr;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  // Occupancy is the pointer distance; the extra MSB disambiguates full from empty.
  assign count       = wr_ptr - rd_ptr;
  assign pop_valid   = (count != '0);
  assign push_ready  = (CW'(DEPTH) - count) >= CW'(ROW);
  assign merge_ready = count >= CW'(ROW);
  assign pop_data    = pop_valid ? mem[rd_idx] : '0;

  assign push_acc  = push_valid  && push_ready  && !clear;
  assign pop_acc   = pop_en      && pop_valid   && !clear;
  assign merge_acc = merge_valid && merge_ready && !clear;

  // Per-slot overlay enable: opaque sprite pixel over a non-sprite entry.
  // Slot 0 is skipped when it is popped this cycle; it leaves with its old value.
  always_comb begin
    merge_wr = '0;
    for (int i = 0; i < int'(ROW); i++) begin
      if (merge_acc
          && (merge_data[i*PX_W +: 2] != 2'b00)
          && !mem[rd_idx + AW'(i)][PX_W-1]
          && !(i == 0 && pop_acc)) begin
        merge_wr[i] = 1'b1;
      end
    end
  end

  // Pointer state.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + CW'(ROW);
      if (pop_acc)  rd_ptr <= rd_ptr + CW'(1);
    end
  end

  // Sticky underflow flag; only rstN clears it.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      underflow_err <= 1'b0;
    end else if (pop_en && !pop_valid) begin
      underflow_err <= 1'b1;
    end
  end

  // Storage: push region (tail) and merge region (head) never overlap.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(ROW); i++) begin
      if (push_acc)    mem[wr_idx + AW'(i)] <= push_data[i*PX_W +: PX_W];
      if (merge_wr[i]) mem[rd_idx + AW'(i)] <= merge_data[i*PX_W +: PX_W];
    end
  end

endmodule
